// File: rtl/dct_it_transpose.sv
// Ping-pong 8x8 transpose buffer between the inverse binDCT row and column passes.
// Rows are written into one bank while the other bank drains column by column.
// Optional macro IDCT_TP_SAT_EN: saturate samples to W_O bits instead of truncating.
module dct_it_transpose #(
  parameter int unsigned W_I = 16,
  parameter int unsigned W_O = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [7:0][W_I-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [7:0][W_O-1:0]  out_data,
  output logic [2:0]                  out_col,
  output logic                        out_last
);

  localparam int unsigned N_BANK = 2;
  localparam int unsigned N_DIM  = 8;
  localparam int unsigned IDX_W  = 3;

  // Reduce one sample from W_I to W_O bits.
  function automatic logic [W_O-1:0] narrow(input logic [W_I-1:0] x);
`ifdef IDCT_TP_SAT_EN
    logic [W_I-W_O:0] hi;
    hi = x[W_I-1:W_O-1];
    if (hi == {(W_I-W_O+1){x[W_I-1]}}) begin
      narrow = x[W_O-1:0];
    end else if (x[W_I-1]) begin
      narrow = {1'b1, {(W_O-1){1'b0}}};
    end else begin
      narrow = {1'b0, {(W_O-1){1'b1}}};
    end
`else
    narrow = W_O'(x);
`endif
  endfunction

  logic [W_O-1:0]       mem_q [N_BANK][N_DIM][N_DIM];

  logic                 wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]     wr_row_q,  wr_row_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]     rd_col_q,  rd_col_d;
  logic [N_BANK-1:0]    bank_full_q, bank_full_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0][W_O-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]     out_col_q, out_col_d;
  logic                 out_last_q, out_last_d;

  logic                 wr_fire_c;
  logic                 rd_fire_c;
  logic [7:0][W_O-1:0]  row_n_c;

  // Narrow the incoming row lane by lane.
  always_comb begin
    row_n_c = '0;
    for (int unsigned i = 0; i < N_DIM; i++) begin
      row_n_c[i] = narrow(in_data[i]);
    end
  end

  // Next-state: write pointer, read pointer, bank occupancy and output register.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_row_d    = wr_row_q;
    rd_bank_d   = rd_bank_q;
    rd_col_d    = rd_col_q;
    bank_full_d = bank_full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;

    wr_fire_c = in_valid & in_ready_q;
    rd_fire_c = bank_full_q[rd_bank_q] & (~out_valid_q | out_ready);

    if (wr_fire_c) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end
    end

    if (rd_fire_c) begin
      for (int unsigned r = 0; r < N_DIM; r++) begin
        out_data_d[r] = mem_q[rd_bank_q][IDX_W'(r)][rd_col_q];
      end
      out_col_d   = rd_col_q;
      out_last_d  = (rd_col_q == 3'd7);
      out_valid_d = 1'b1;
      rd_col_d    = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
      end
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end

    // Registered ready: reflects occupancy of the bank the next row would go to.
    in_ready_d = ~bank_full_d[wr_bank_d];
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_col_q    <= '0;
      bank_full_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_row_q    <= wr_row_d;
      rd_bank_q   <= rd_bank_d;
      rd_col_q    <= rd_col_d;
      bank_full_q <= bank_full_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      for (int unsigned i = 0; i < N_DIM; i++) begin
        mem_q[wr_bank_q][wr_row_q][IDX_W'(i)] <= row_n_c[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct_it_transpose.sv
// Randomized bench for dct_it_transpose with a block-level transpose model.
module tb_dct_it_transpose;

  localparam int unsigned W_I = 16;
  localparam int unsigned W_O = 12;

  logic                        clk;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [7:0][W_I-1:0]  in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [7:0][W_O-1:0]  out_data;
  logic [2:0]                  out_col;
  logic                        out_last;

  dct_it_transpose #(.W_I(W_I), .W_O(W_O)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: rows of the block being filled, and expected columns in order.
  longint rowbuf [8][8];
  int     nrows = 0;
  longint exp_q[$];
  int     exp_col_q[$];
  int     run_len = 0;
  int     max_run = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Signed narrowing done with integer arithmetic.
  function automatic longint narrow_m(input longint v);
    longint lim;
    longint t;
    lim = longint'(1) << (W_O - 1);
`ifdef IDCT_TP_SAT_EN
    if (v > lim - 1) t = lim - 1;
    else if (v < -lim) t = -lim;
    else t = v;
`else
    t = v & ((lim << 1) - 1);
    if (t >= lim) t = t - (lim << 1);
`endif
    return t;
  endfunction

  // Handshakes observed mid-cycle; they take effect at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_col_q.size() == 0) begin
          check("unexpected_column", 1, 0);
        end else begin
          check("out_col", out_col, exp_col_q[0]);
          check("out_last", out_last, (exp_col_q[0] == 7) ? 1 : 0);
          for (int r = 0; r < 8; r++) check("out_data", $signed(out_data[r]), exp_q[r]);
          if (out_ready) begin
            void'(exp_col_q.pop_front());
            for (int r = 0; r < 8; r++) void'(exp_q.pop_front());
          end
        end
      end else begin
        run_len = 0;
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < 8; i++) rowbuf[nrows][i] = longint'($signed(in_data[i]));
        nrows++;
        if (nrows == 8) begin
          for (int c = 0; c < 8; c++) begin
            exp_col_q.push_back(c);
            for (int r = 0; r < 8; r++) exp_q.push_back(narrow_m(rowbuf[r][c]));
          end
          nrows = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [W_I-1:0] rnd_sample();
    return W_I'($urandom);
  endfunction

  // Mode 0: 8r+c pattern, 1: random, 2: row0 max / row1 min / rest random.
  task automatic fill_row(input int mode, input int r);
    for (int c = 0; c < 8; c++) begin
      case (mode)
        0:       in_data[c] = W_I'(8 * (r % 8) + c);
        2:       in_data[c] = (r == 0) ? 16'sh7FFF : (r == 1) ? -16'sd32768 : rnd_sample();
        default: in_data[c] = rnd_sample();
      endcase
    end
  endtask

  // Send n rows back to back, holding each until accepted.
  task automatic send_rows(input int n, input int mode, input bit chk_rdy);
    bit acc;
    int guard;
    for (int r = 0; r < n; r++) begin
      fill_row(mode, r);
      in_valid = 1'b1;
      guard = 0;
      do begin
        acc = in_ready;
        if (chk_rdy) check("b2b_in_ready", in_ready, 1);
        step();
        guard++;
      end while (!acc && guard < 200);
      if (!acc) check("send_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_col_q.size() != 0 || out_valid) && guard < 200) begin
      step();
      guard++;
    end
    check("drain_empty", exp_col_q.size(), 0);
    check("valid_dropped", out_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, (out_data == '0) ? 1 : 0, 1);
    check({tag, "_out_col"}, out_col, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  initial begin
    int acc_cnt;
    int guard;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    fill_row(1, 0);

    // Reset held with a row offered.
    repeat (3) step();
    check_reset_vals("rst");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();

    // Single block with known pattern; latency and column contents.
    out_ready = 1'b1;
    send_rows(8, 0, 1'b0);
    check("lat_edge_n", out_valid, 0);
    step();
    check("lat_edge_n1", out_valid, 1);
    check("first_col", out_col, 0);
    check("pattern_r3c0", $signed(out_data[3]), 24);
    drain();

    // Four back-to-back random blocks at full rate.
    max_run = 0;
    send_rows(32, 1, 1'b1);
    drain();
    check("b2b_run", max_run, 32);

    // Backpressure: both banks fill, input stalls.
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int k = 0; k < 20; k++) begin
      fill_row(1, k);
      in_valid = 1'b1;
      if (in_ready) acc_cnt++;
      step();
    end
    in_valid = 1'b0;
    check("bp_rows_accepted", acc_cnt, 16);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_hold_col", out_col, 0);
    out_ready = 1'b1;
    repeat (6) step();
    check("bp_ready_before", in_ready, 0);
    step();
    check("bp_ready_after", in_ready, 1);
    check("bp_col7", out_col, 7);
    check("bp_last", out_last, 1);
    drain();

    // Narrowing of extreme values.
    send_rows(8, 2, 1'b0);
    guard = 0;
    while (!out_valid && guard < 20) begin
      step();
      guard++;
    end
    check("sat_wait", out_valid, 1);
`ifdef IDCT_TP_SAT_EN
    check("narrow_max", $signed(out_data[0]), 2047);
    check("narrow_min", $signed(out_data[1]), -2048);
`else
    check("narrow_max", $signed(out_data[0]), -1);
    check("narrow_min", $signed(out_data[1]), 0);
`endif
    drain();

    // Reset in the middle of a block discards the partial rows.
    send_rows(5, 1, 1'b0);
    in_valid = 1'b1;
    rst_n    = 1'b0;
    nrows    = 0;
    #2;
    check_reset_vals("midrst");
    step();
    check_reset_vals("midrst_hold");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    send_rows(8, 1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
